hc112_ripple_mon: RTL and testbench
===================================

Name: hc112_ripple_mon

Overview:
- Synchronous monitor sitting directly downstream of the hc112 dual JK flip-flop.
- Consumes Q1/Q2 when both flip-flops are wired in toggle mode as a 2-bit ripple divider (Q1 output clocks stage 2).
- Synchronises both outputs into the system clock domain, detects their edges and counts Q1/Q2 rising edges.
- Runs a checker FSM that locks when Q2 toggles on every Q1 falling edge and flags any violation.

Parameters:
- CW, 8, width of the two edge counters.
- LOCKN, 4, consecutive good ripple steps required to reach LOCK (1..15).

Ports:
- CP  input  1  system clock; all state updates on rising edge.
- RDN  input  1  reset, synchronous, active-low.
- EN  input  1  1 = counters and FSM advance; 0 = freeze them (synchronisers still run).
- CLR  input  1  synchronous clear of counters, FSM and error flag; acts regardless of EN.
- Q1  input  1  hc112 stage-1 output, asynchronous to CP.
- Q2  input  1  hc112 stage-2 output, asynchronous to CP.
- Q1S  output  1  synchronised Q1.
- Q2S  output  1  synchronised Q2.
- Q1RE  output  1  one-cycle pulse, Q1S rising.
- Q1FE  output  1  one-cycle pulse, Q1S falling.
- Q2TG  output  1  one-cycle pulse, Q2S changed (either direction).
- CNT1  output  CW  count of Q1S rising edges.
- CNT2  output  CW  count of Q2S rising edges.
- STATE  output  2  FSM state: IDLE=00, TRACK=01, LOCK=10, ERR=11.
- LOCKED  output  1  1 while STATE==LOCK.
- ERRF  output  1  sticky error flag.

Behaviour:
- Reset (RDN=0 at CP edge): all registers 0, including sync stages and delay registers; STATE=IDLE; every output 0.
- Sync path:
  - Two flops per input; Q1S/Q2S are the second stage.
  - A level present at Q1 before edge n appears on Q1S after edge n+1.
- Edge pulses:
  - Registered compare of Q1S/Q2S against a one-cycle-delayed copy.
  - Each pulse is high for exactly one CP cycle, after edge n+2.
  - Edge detection is never gated by EN.
- Counters:
  - CNT1 += 1 on Q1RE; CNT2 += 1 on Q1S-equivalent rising of Q2S.
  - Both wrap modulo 2^CW (all-ones -> 0), no saturation, no flag.
  - Priority: RDN > CLR > EN=0 hold > increment.
- FSM (advances only when EN=1; CLR forces IDLE, clears ERRF, good-step count and pending flag):
  - IDLE: on Q1FE -> TRACK, set pending, goodcnt=0. A Q2TG seen in IDLE is ignored.
  - TRACK/LOCK window:
    - Q1FE sets pending.
    - Q2TG in the same cycle as Q1FE, or in the following cycle while pending, is a good step: clear pending, goodcnt += 1.
    - Pending still set one cycle after Q1FE with no Q2TG -> ERR.
    - Q2TG while not pending and not coincident with Q1FE -> ERR.
  - TRACK -> LOCK when goodcnt reaches LOCKN. goodcnt saturates at LOCKN.
  - LOCK: any violation -> ERR.
  - ERR: sticky; ERRF=1; only CLR or reset leaves it (-> IDLE).
- Simultaneous events:
  - CLR with a violation in the same cycle: CLR wins, STATE=IDLE, ERRF=0.
  - Q1FE coincident with an expiring window: evaluate the expiry first (-> ERR).
  - EN=0 mid-window: pending and window timer hold; evaluation resumes when EN=1. Pulses arriving while EN=0 are lost to the FSM.
- Reset mid-operation: everything returns to reset values at that edge; the first valid Q1S occurs two edges after RDN rises.

Test Plan:
- Reset: RDN=0 for 3 cycles with Q1=Q2=1 -> all outputs 0. After RDN=1, Q1S=1 on the 2nd edge and Q1RE pulses once on the 3rd.
- Ideal ripple: Q1 toggles every 4 CP cycles, Q2 toggles 1 cycle after each Q1 fall -> TRACK after 1st fall, LOCKED=1 after 4th good step, ERRF=0.
- Missing toggle: after LOCK, suppress one Q2 toggle -> STATE=11 and ERRF=1 two cycles after that Q1FE; persists until CLR -> STATE=00, ERRF=0, CNT1=CNT2=0.
- Spurious Q2: in TRACK, toggle Q2 with Q1 steady -> ERR. CLR asserted in the same cycle as the violation -> STATE=00, ERRF=0.
- Wrap: CW=4, drive 17 Q1 rising edges -> CNT1=1. With EN=0 during 3 further edges -> CNT1 stays 1 while Q1RE still pulses.
- Skew edge: Q2TG coincident with Q1FE, then Q2TG one cycle late, then two cycles late -> the first two are good steps, the third gives ERR.

Source files
------------

// File: rtl/hc112_ripple_mon.sv
// Monitor for an hc112 wired as a 2-bit ripple divider: syncs Q1/Q2, detects
// edges, counts rising edges and checks that Q2 toggles on every Q1 fall.
module hc112_ripple_mon #(
  parameter int CW    = 8,
  parameter int LOCKN = 4
) (
  input  logic          CP,
  input  logic          RDN,
  input  logic          EN,
  input  logic          CLR,
  input  logic          Q1,
  input  logic          Q2,
  output logic          Q1S,
  output logic          Q2S,
  output logic          Q1RE,
  output logic          Q1FE,
  output logic          Q2TG,
  output logic [CW-1:0] CNT1,
  output logic [CW-1:0] CNT2,
  output logic [1:0]    STATE,
  output logic          LOCKED,
  output logic          ERRF
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    TRACK = 2'b01,
    LOCK  = 2'b10,
    ERR   = 2'b11
  } state_t;

  logic q1_m, q2_m, q1_d, q2_d, q2_re;

  state_t     state_q, state_n;
  logic       pend_q, pend_n;
  logic [3:0] good_q, good_n;
  logic       err_q, err_n;
  logic       good_step, viol;

  // Two-flop synchronisers, then edge pulses registered against a delayed copy.
  always_ff @(posedge CP) begin
    if (!RDN) begin
      q1_m  <= 1'b0;
      q2_m  <= 1'b0;
      Q1S   <= 1'b0;
      Q2S   <= 1'b0;
      q1_d  <= 1'b0;
      q2_d  <= 1'b0;
      Q1RE  <= 1'b0;
      Q1FE  <= 1'b0;
      Q2TG  <= 1'b0;
      q2_re <= 1'b0;
    end else begin
      q1_m  <= Q1;
      q2_m  <= Q2;
      Q1S   <= q1_m;
      Q2S   <= q2_m;
      q1_d  <= Q1S;
      q2_d  <= Q2S;
      Q1RE  <= Q1S & ~q1_d;
      Q1FE  <= ~Q1S & q1_d;
      Q2TG  <= Q2S ^ q2_d;
      q2_re <= Q2S & ~q2_d;
    end
  end

  always_ff @(posedge CP) begin
    if (!RDN) begin
      CNT1 <= '0;
      CNT2 <= '0;
    end else if (CLR) begin
      CNT1 <= '0;
      CNT2 <= '0;
    end else if (EN) begin
      if (Q1RE)  CNT1 <= CNT1 + CW'(1);
      if (q2_re) CNT2 <= CNT2 + CW'(1);
    end
  end

  always_ff @(posedge CP) begin
    if (!RDN) begin
      state_q <= IDLE;
      pend_q  <= 1'b0;
      good_q  <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      pend_q  <= pend_n;
      good_q  <= good_n;
      err_q   <= err_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    pend_n    = pend_q;
    good_n    = good_q;
    err_n     = err_q;
    good_step = 1'b0;
    viol      = 1'b0;
    if (CLR) begin
      state_n = IDLE;
      pend_n  = 1'b0;
      good_n  = 4'd0;
      err_n   = 1'b0;
    end else if (EN) begin
      case (state_q)
        IDLE: begin
          if (Q1FE) begin
            state_n = TRACK;
            pend_n  = 1'b1;
            good_n  = 4'd0;
          end
        end
        TRACK, LOCK: begin
          // An open window is resolved before a new Q1 fall is considered.
          if (pend_q) begin
            if (Q2TG) begin
              good_step = 1'b1;
              pend_n    = Q1FE;
            end else begin
              viol = 1'b1;
            end
          end else if (Q1FE) begin
            if (Q2TG) good_step = 1'b1;
            else      pend_n    = 1'b1;
          end else if (Q2TG) begin
            viol = 1'b1;
          end
          if (viol) begin
            state_n = ERR;
            err_n   = 1'b1;
            pend_n  = 1'b0;
          end else if (good_step) begin
            if (good_q < 4'(LOCKN)) good_n = good_q + 4'd1;
            if (good_q + 4'd1 >= 4'(LOCKN)) state_n = LOCK;
          end
        end
        default: err_n = 1'b1;
      endcase
    end
  end

  assign STATE  = state_q;
  assign LOCKED = (state_q == LOCK);
  assign ERRF   = err_q;

endmodule

// File: tb/tb_hc112_ripple_mon.sv
// Directed bench for hc112_ripple_mon (CW=4, LOCKN=4) with hand-computed expectations.
module tb_hc112_ripple_mon;
  logic       CP = 1'b0;
  logic       RDN, EN, CLR, Q1, Q2;
  logic       Q1S, Q2S, Q1RE, Q1FE, Q2TG, LOCKED, ERRF;
  logic [3:0] CNT1, CNT2;
  logic [1:0] STATE;

  int errs   = 0;
  int checks = 0;

  hc112_ripple_mon #(.CW(4), .LOCKN(4)) dut (
    .CP(CP), .RDN(RDN), .EN(EN), .CLR(CLR), .Q1(Q1), .Q2(Q2),
    .Q1S(Q1S), .Q2S(Q2S), .Q1RE(Q1RE), .Q1FE(Q1FE), .Q2TG(Q2TG),
    .CNT1(CNT1), .CNT2(CNT2), .STATE(STATE), .LOCKED(LOCKED), .ERRF(ERRF)
  );

  always #5 CP = ~CP;

  task automatic cyc(input int n);
    repeat (n) @(posedge CP);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Toggle Q1 and spend 4 cycles; on a fall, toggle Q2 dly cycles later (dly<0: never).
  task automatic half(input int dly);
    Q1 = ~Q1;
    if (Q1 == 1'b0 && dly >= 0) begin
      if (dly > 0) cyc(dly);
      Q2 = ~Q2;
      cyc(4 - dly);
    end else begin
      cyc(4);
    end
  endtask

  task automatic do_clr();
    CLR = 1'b1;
    cyc(1);
    CLR = 1'b0;
  endtask

  initial begin
    RDN = 1'b0; EN = 1'b1; CLR = 1'b0; Q1 = 1'b1; Q2 = 1'b1;
    cyc(3);
    chk("rst_q1s",   32'(Q1S),   0);
    chk("rst_q1re",  32'(Q1RE),  0);
    chk("rst_q2tg",  32'(Q2TG),  0);
    chk("rst_cnt1",  32'(CNT1),  0);
    chk("rst_state", 32'(STATE), 0);
    chk("rst_errf",  32'(ERRF),  0);
    RDN = 1'b1;
    cyc(1);
    chk("sync_e1_q1s", 32'(Q1S), 0);
    cyc(1);
    chk("sync_e2_q1s",  32'(Q1S),  1);
    chk("sync_e2_q1re", 32'(Q1RE), 0);
    cyc(1);
    chk("sync_e3_q1re", 32'(Q1RE), 1);
    chk("sync_e3_q2tg", 32'(Q2TG), 1);
    cyc(1);
    chk("sync_e4_q1re", 32'(Q1RE),  0);
    chk("sync_cnt1",    32'(CNT1),  1);
    chk("sync_cnt2",    32'(CNT2),  1);
    chk("idle_ign_q2",  32'(STATE), 0);

    // Return both inputs low under CLR so the ripple starts from a clean IDLE.
    Q1 = 1'b0; Q2 = 1'b0; CLR = 1'b1;
    cyc(5);
    CLR = 1'b0;
    chk("clr_cnt1", 32'(CNT1), 0);

    // Ideal ripple
    half(-1); half(1);
    chk("rip_track", 32'(STATE), 1);
    half(-1); half(1);
    half(-1); half(1);
    half(-1);
    chk("rip_pre_lock", 32'(LOCKED), 0);
    half(1);
    cyc(2);
    chk("rip_locked", 32'(LOCKED), 1);
    chk("rip_state",  32'(STATE),  2);
    chk("rip_errf",   32'(ERRF),   0);
    chk("rip_cnt1",   32'(CNT1),   4);
    chk("rip_cnt2",   32'(CNT2),   2);

    // Missing Q2 toggle while locked
    half(-1);
    Q1 = 1'b0;
    cyc(3);
    chk("miss_q1fe",  32'(Q1FE),  1);
    chk("miss_lock0", 32'(STATE), 2);
    cyc(1);
    chk("miss_lock1", 32'(STATE), 2);
    cyc(1);
    chk("miss_err",   32'(STATE), 3);
    chk("miss_errf",  32'(ERRF),  1);
    cyc(3);
    chk("miss_sticky", 32'(STATE), 3);
    do_clr();
    chk("miss_clr_state", 32'(STATE), 0);
    chk("miss_clr_errf",  32'(ERRF),  0);
    chk("miss_clr_cnt1",  32'(CNT1),  0);
    chk("miss_clr_cnt2",  32'(CNT2),  0);

    // Spurious Q2 in TRACK
    half(-1); half(1);
    cyc(3);
    chk("spur_track", 32'(STATE), 1);
    Q2 = ~Q2;
    cyc(4);
    chk("spur_err",  32'(STATE), 3);
    chk("spur_errf", 32'(ERRF),  1);
    do_clr();

    // Spurious Q2 with CLR in the violation cycle
    half(-1); half(1);
    cyc(3);
    Q2 = ~Q2;
    cyc(3);
    CLR = 1'b1;
    cyc(1);
    CLR = 1'b0;
    chk("spurclr_state", 32'(STATE), 0);
    chk("spurclr_errf",  32'(ERRF),  0);
    cyc(2);
    chk("spurclr_hold",  32'(STATE), 0);

    // Skew: coincident and one-late are good, two-late is a violation
    half(-1); half(1);
    half(-1); half(0);
    half(-1); half(1);
    half(-1);
    chk("skew_track", 32'(STATE), 1);
    half(2);
    chk("skew_window", 32'(STATE), 1);
    cyc(1);
    chk("skew_err", 32'(STATE), 3);

    // Counter wrap with CW=4
    CLR = 1'b1;
    cyc(3);
    CLR = 1'b0;
    for (int i = 0; i < 17; i++) begin
      half(-1); half(-1);
    end
    cyc(3);
    chk("wrap_cnt1", 32'(CNT1), 1);
    chk("wrap_cnt2", 32'(CNT2), 0);
    EN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      Q1 = 1'b1;
      cyc(3);
      chk("en0_q1re", 32'(Q1RE), 1);
      cyc(1);
      Q1 = 1'b0;
      cyc(4);
    end
    chk("en0_cnt1", 32'(CNT1), 1);
    chk("en0_errf", 32'(ERRF), 1);
    EN = 1'b1;
    Q1 = 1'b1;
    cyc(5);
    chk("en1_cnt1", 32'(CNT1), 2);

    // Reset mid-operation
    RDN = 1'b0;
    cyc(1);
    chk("mid_rst_cnt1",  32'(CNT1),  0);
    chk("mid_rst_state", 32'(STATE), 0);
    chk("mid_rst_q1s",   32'(Q1S),   0);
    RDN = 1'b1;
    cyc(1);
    chk("mid_rst_e1_q1s", 32'(Q1S), 0);
    cyc(1);
    chk("mid_rst_e2_q1s", 32'(Q1S), 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
